aibnd_dcc_sel_ctl: RTL

- Sequencer that drives the select input of the DCC clock mux.
- Holds the mux on the raw clock (clk0) until the duty-cycle corrector reports stable lock, then switches to the corrected clock (clk1).
- Falls back to clk0 on lock loss, lock timeout, disable or forced bypass.
- Sits directly upstream of the mux select pin; mux_sel is a registered, single-flop output so the select never glitches.

---
 rtl/aibnd_dcc_sel_ctl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/aibnd_dcc_sel_ctl.sv
// Purpose: sequences the DCC clock-mux select, moving from clk0 to clk1 once lock is stable.
// Latency: first edge sampling dcc_lock=1 -> mux_sel=1 after SYNC_STAGES+1+SETTLE_CYC edges.
// Backpressure: none; the inputs are levels, and abort (disable/bypass) always wins.
module aibnd_dcc_sel_ctl #(
    parameter int SYNC_STAGES  = 2,
    parameter int SETTLE_CYC   = 16,
    parameter int LOCK_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dcc_en,
    input  logic       force_bypass,
    input  logic       dcc_lock,
    input  logic       clr_sticky,
    output logic       mux_sel,
    output logic       sel_done,
    output logic       err_timeout,
    output logic       err_lock_lost,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        SEL       = 3'd3,
        FALLBACK  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   mux_sel_q, mux_sel_d;
    logic                   err_to_q, err_to_d;
    logic                   err_ll_q, err_ll_d;
    logic                   lock_s;
    logic                   abort;
    logic                   set_to;
    logic                   set_ll;

    // dcc_lock only enters the logic through this shift chain.
    assign lock_s = sync_q[SYNC_STAGES-1];
    assign abort  = !dcc_en || force_bypass;

    // Synchronizer shift: new sample enters bit 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], dcc_lock};
    end

    // Next-state and counter; abort is checked first in every active state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        set_to  = 1'b0;
        set_ll  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (lock_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = FALLBACK;
                    set_to  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!lock_s) begin
                    // A lock bounce restarts the whole timeout window.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = SEL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEL: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!lock_s) begin
                    state_d = FALLBACK;
                    set_ll  = 1'b1;
                end
            end
            FALLBACK: begin
                // Re-arming needs a pass through IDLE, i.e. one aborted cycle.
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Select follows the next state so it changes on the same edge as the state.
    always_comb begin
        mux_sel_d = (state_d == SEL);
        err_to_d  = set_to ? 1'b1 : (clr_sticky ? 1'b0 : err_to_q);
        err_ll_d  = set_ll ? 1'b1 : (clr_sticky ? 1'b0 : err_ll_q);
    end

    // All state, including the synchronizer, clears on synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sync_q    <= '0;
            mux_sel_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ll_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            mux_sel_q <= mux_sel_d;
            err_to_q  <= err_to_d;
            err_ll_q  <= err_ll_d;
        end
    end

    assign mux_sel       = mux_sel_q;
    assign sel_done      = mux_sel_q;
    assign err_timeout   = err_to_q;
    assign err_lock_lost = err_ll_q;
    assign state_o       = state_q;

endmodule
